// File: rtl/sram_bank_controller.sv
// Bus-to-SRAM bridge: decodes a byte address onto N_SRAM single-port banks,
// runs one access at a time with read wait states and sram_wait stalls.
// Ports:
//   CLK, RST                : clock, synchronous active-high reset
//   req_valid/ready/wen     : bus request handshake and direction
//   req_addr/wdata/byte_en  : byte address, write data, lane enables
//   rsp_valid/ready         : response handshake with backpressure
//   rsp_rdata, rsp_err      : read data (0 on write/error), decode error
//   wen, ram_wData, addr    : SRAM write enable, write data, word index
//   byte_en, sram_en        : SRAM lane enables, one-hot bank enable
//   ram_rData, sram_wait    : packed per-bank read data, SRAM stall
module sram_bank_controller #(
    parameter int N_SRAM      = 1,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int BANK_AW     = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_wen,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    input  logic [DATA_W/8-1:0]        req_byte_en,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic                       wen,
    output logic [DATA_W-1:0]          ram_wData,
    output logic [BANK_AW-1:0]         addr,
    output logic [DATA_W/8-1:0]        byte_en,
    output logic [N_SRAM-1:0]          sram_en,
    input  logic [N_SRAM*DATA_W-1:0]   ram_rData,
    input  logic                       sram_wait
);

    localparam int BE_W     = DATA_W / 8;
    localparam int BYTE_OFF = $clog2(BE_W);
    localparam int SEL_W    = (N_SRAM > 1) ? $clog2(N_SRAM) : 1;
    localparam int CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int UP_LSB   = BYTE_OFF + BANK_AW + SEL_W;

    localparam logic [SEL_W:0]   NBANK = (SEL_W + 1)'(N_SRAM);
    localparam logic [CNT_W-1:0] WS_C  = CNT_W'(WAIT_STATES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_wen;
    logic [BANK_AW-1:0] r_word;
    logic [SEL_W-1:0]   r_bank;
    logic [DATA_W-1:0]  r_wdata;
    logic [BE_W-1:0]    r_be;
    logic               r_err;
    logic [DATA_W-1:0]  r_rdata;

    logic [BANK_AW-1:0] w_word;
    logic [SEL_W-1:0]   w_bank;
    logic               w_upper_nz;
    logic               w_err;
    logic               w_access;
    logic [N_SRAM-1:0]  w_en;
    logic [DATA_W-1:0]  w_rsel;
    logic               w_unused_addr;

    assign w_word = req_addr[BYTE_OFF +: BANK_AW];
    assign w_bank = req_addr[BYTE_OFF + BANK_AW +: SEL_W];

    // Byte-offset bits never reach the SRAM; fold them so nothing dangles.
    assign w_unused_addr = ^req_addr;

    generate
        if (UP_LSB < ADDR_W) begin : g_upper
            assign w_upper_nz = |req_addr[ADDR_W-1:UP_LSB];
        end else begin : g_no_upper
            assign w_upper_nz = 1'b0;
        end
    endgenerate

    assign w_err = ({1'b0, w_bank} >= NBANK) | w_upper_nz;

    always_comb begin
        w_en   = '0;
        w_rsel = '0;
        for (int i = 0; i < N_SRAM; i++) begin
            if (r_bank == SEL_W'(i)) begin
                w_en[i] = 1'b1;
                w_rsel  = ram_rData[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_wen   <= 1'b0;
            r_word  <= '0;
            r_bank  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_wen   <= req_wen;
                        r_word  <= w_word;
                        r_bank  <= w_bank;
                        r_wdata <= req_wdata;
                        r_be    <= req_byte_en;
                        r_err   <= w_err;
                        r_cnt   <= '0;
                        r_rdata <= '0;
                        r_state <= w_err ? S_RESP : S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // A stalled cycle freezes both the counter and the state.
                    if (!sram_wait) begin
                        if (r_wen) begin
                            r_state <= S_RESP;
                        end else if (r_cnt == WS_C) begin
                            r_rdata <= w_rsel;
                            r_state <= S_RESP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_access  = (r_state == S_ACCESS);
    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = rsp_valid ? r_rdata : '0;
    assign rsp_err   = rsp_valid & r_err;

    assign sram_en   = w_access ? w_en : '0;
    assign wen       = w_access & r_wen;
    assign addr      = w_access ? r_word : '0;
    assign ram_wData = w_access ? r_wdata : '0;
    assign byte_en   = w_access ? r_be : '0;

endmodule

// File: doc/sram_bank_controller.md
# sram_bank_controller

Parametrised multi-bank SRAM controller that sits between a bus-side request/response port (fed by the AHB slave logic) and N_SRAM single-port SRAM macros. Generalises the fixed 32-bit SRAM controller port with configurable data width, bank count and bank depth. Adds byte-address bank decoding, programmable read wait states, `sram_wait` stall handling, out-of-range error responses and a valid/ready response handshake with backpressure.

## Interface
- N_SRAM, 1: number of SRAM banks (1..16)
- DATA_W, 32: data width in bits; multiple of 8
- ADDR_W, 32: bus byte-address width
- BANK_AW, 10: word-address bits per bank (depth 2^BANK_AW words)
- WAIT_STATES, 0: extra read cycles before `ram_rData` is sampled (0..15)

Derived:
- BYTE_OFF = clog2(DATA_W/8)
- SEL_W = max(1, clog2(N_SRAM))

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- req_valid  in  1  bus request present
- req_ready  out  1  controller accepts a request this cycle
- req_wen  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_byte_en  in  DATA_W/8  byte lane enables
- rsp_valid  out  1  response present
- rsp_ready  in  1  bus consumes the response
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  decode error
- wen  out  1  SRAM write enable
- ram_wData  out  DATA_W  SRAM write data
- addr  out  BANK_AW  word index within the selected bank
- byte_en  out  DATA_W/8  SRAM byte enables
- sram_en  out  N_SRAM  one-hot bank enable
- ram_rData  in  N_SRAM x DATA_W  per-bank read data
- sram_wait  in  1  SRAM stall; extends the current access

## Operation
- Decode fields:
  - word = req_addr[BYTE_OFF +: BANK_AW]
  - bank = req_addr[BYTE_OFF+BANK_AW +: SEL_W]
  - upper = all bits above the bank field
- Decode error when bank >= N_SRAM or upper != 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch wen/word/bank/wdata/byte_en/err and clear the counter.
  - Next state: err ? RESP : ACCESS.
- ACCESS:
  - sram_en[bank] = 1; wen, addr, ram_wData, byte_en are driven from the latched values.
  - While sram_wait = 1: hold all outputs; the counter does not advance.
  - Write: completes on the first cycle with sram_wait = 0; go to RESP.
  - Read: counter increments on each sram_wait = 0 cycle. On the cycle with sram_wait = 0 and counter == WAIT_STATES, capture ram_rData[bank] into rsp_rdata and go to RESP.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready, go to IDLE.
- req_ready = 0 in ACCESS and RESP. One outstanding transaction only.
- When not in ACCESS: sram_en, wen, addr, ram_wData and byte_en are all 0.
- An error response never asserts any sram_en bit. rsp_rdata = 0 and rsp_err = 1.
- byte_en is passed through for reads as well. A write with byte_en = 0 still runs a normal access cycle.

## Timing
- Reset: state = IDLE, counter = 0. Every output = 0 except req_ready = 1 from the first cycle after reset.
- Reset asserted mid-ACCESS or mid-RESP: sram_en and rsp_valid drop in the next cycle. The transaction is discarded with no response.
- Request accepted at cycle 0, no stalls:
  - write: ACCESS at cycle 1, rsp_valid at cycle 2
  - read: ACCESS at cycles 1..1+WAIT_STATES, rsp_valid at cycle 2+WAIT_STATES
- Each sram_wait = 1 cycle adds exactly one cycle of latency.
- Error request: rsp_valid at cycle 1.
- Earliest next acceptance is the cycle after the rsp_valid && rsp_ready handshake. Peak throughput is 1 access per 3 cycles (WAIT_STATES = 0).
- rsp_valid, rsp_rdata and rsp_err do not change while rsp_valid = 1 and rsp_ready = 0.
- The counter is wide enough for WAIT_STATES and never wraps within an access.

## Test plan
1. N_SRAM=3, DATA_W=32, BANK_AW=10. Write 0xDEADBEEF to 0x1004 with byte_en=0xF.
   - Response: cycle 1 sram_en=3'b010, wen=1, addr=1; cycle 2 rsp_valid=1, rsp_err=0.
   - Then read 0x1004 with the model returning 0xDEADBEEF: rsp_rdata=0xDEADBEEF.
2. WAIT_STATES=2. Read 0x0008.
   - Response: sram_en[0] high for cycles 1-3, addr=2, rsp_valid at cycle 4, data sampled at cycle 3.
3. WAIT_STATES=0. Read 0x2000 with sram_wait high at cycles 1-2.
   - Response: sram_en[2] held at cycles 1-3, rsp_valid at cycle 4.
4. N_SRAM=3. Reads of 0x3000 (bank 3) and 0x10000 (upper bit set).
   - Response: each gives rsp_valid at cycle 1 with rsp_err=1, rsp_rdata=0, sram_en=0 throughout.
5. Hold rsp_ready low for 5 cycles while a request is pending.
   - Response: rsp_valid and rsp_rdata stable and req_ready=0 for all 5 cycles. IDLE and req_ready=1 the cycle after rsp_ready rises.
6. Assert RST during ACCESS with sram_wait held high.
   - Response: next cycle sram_en=0, rsp_valid=0, req_ready=1, and no response is ever produced.
